// File: rtl/set_assoc_cache.sv
// set_assoc_cache: set-associative hit/miss model with true-LRU tag tracking and no data storage.
// Latency: 1 cycle from an accepted access to hit_valid/hit; hits/accesses update on the same edge.
// Backpressure: addr_ready=1 in IDLE and 0 for the SETS-cycle set walk after a flush request.
// Ports: clk, rst_n (sync, active-low); addr_in/addr_valid/addr_ready access handshake;
//        flush invalidates all lines; hit_valid/hit per-access result; hits/accesses saturating
//        totals; win_valid/win_hits windowed statistics.
// Optional feature macro: SAC_WINDOW_STATS_EN (windowed hit statistics; outputs tied to 0 when undefined).
module set_assoc_cache #(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 64,
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_W       = 21,
  parameter int WINDOW      = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic              flush,
  output logic              hit_valid,
  output logic              hit,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  accesses,
  output logic              win_valid,
  output logic [CNT_W-1:0]  win_hits
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  // With WAYS=1 the age field is a single bit that is only ever written 0.
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] flush_idx;

  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0] age_q   [SETS][WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             accept;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] hit_age;
  logic             has_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim;
  logic             unused_ok;

  assign idx = addr_in[OFF_W +: IDX_W];
  assign tag = addr_in[ADDR_W-1 -: TAG_W];

  // Offset bits carry no meaning for a tag-only model.
  assign unused_ok = (^addr_in) ^ (WINDOW > 0);

  // addr_ready is a registered copy of "state == IDLE"; flush wins over a same-cycle access.
  assign accept = addr_valid && addr_ready && !flush;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    hit_age = '0;
    has_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
        hit_age = age_q[idx][w];
      end
      if (age_q[idx][w] == OLDEST) begin
        lru_way = WAY_W'(w);
      end
    end
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim = has_inv ? inv_way : lru_way;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_idx  <= '0;
      addr_ready <= 1'b1;
      hit_valid  <= 1'b0;
      hit        <= 1'b0;
      hits       <= '0;
      accesses   <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= '0;
        end
      end
    end else begin
      hit_valid <= accept;
      hit       <= accept && hit_any;
      case (state)
        IDLE: begin
          if (flush) begin
            state      <= FLUSH;
            flush_idx  <= '0;
            addr_ready <= 1'b0;
          end else if (accept) begin
            if (accesses != {CNT_W{1'b1}}) accesses <= accesses + 1'b1;
            if (hit_any && (hits != {CNT_W{1'b1}})) hits <= hits + 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              if (hit_any) begin
                // Only ways younger than the hit way age, keeping ages a permutation.
                if (WAY_W'(w) == hit_way) begin
                  age_q[idx][w] <= '0;
                end else if (valid_q[idx][w] && (age_q[idx][w] < hit_age)) begin
                  age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
              end else if (WAY_W'(w) == victim) begin
                valid_q[idx][w] <= 1'b1;
                tag_q[idx][w]   <= tag;
                age_q[idx][w]   <= '0;
              end else if (valid_q[idx][w] && (age_q[idx][w] != OLDEST)) begin
                age_q[idx][w] <= age_q[idx][w] + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[flush_idx][w] <= 1'b0;
            age_q[flush_idx][w]   <= '0;
          end
          if (flush_idx == IDX_W'(SETS - 1)) begin
            state      <= IDLE;
            addr_ready <= 1'b1;
          end
          flush_idx <= flush_idx + 1'b1;
        end
        default: begin
          state      <= IDLE;
          addr_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SAC_WINDOW_STATS_EN
  localparam int WC_W = $clog2(WINDOW + 1);

  logic [WC_W-1:0]  win_cnt;
  logic [CNT_W-1:0] win_acc;

  // Window state survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      win_acc   <= '0;
      win_valid <= 1'b0;
      win_hits  <= '0;
    end else begin
      win_valid <= 1'b0;
      if (accept) begin
        if (win_cnt == WC_W'(WINDOW - 1)) begin
          win_valid <= 1'b1;
          win_hits  <= win_acc + CNT_W'(hit_any);
          win_cnt   <= '0;
          win_acc   <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          win_acc <= win_acc + CNT_W'(hit_any);
        end
      end
    end
  end
`else
  assign win_valid = 1'b0;
  assign win_hits  = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;

  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam int CNT_MAX = (1 << 21) - 1;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_in;
  logic        addr_valid;
  logic        addr_ready;
  logic        flush;
  logic        hit_valid;
  logic        hit;
  logic [20:0] hits;
  logic [20:0] accesses;
  logic        win_valid;
  logic [20:0] win_hits;

  logic [31:0] s_addr;
  logic        s_valid;
  logic        s_ready;
  logic        s_hit_valid;
  logic        s_hit;
  logic [3:0]  s_hits;
  logic [3:0]  s_accesses;
  logic        s_win_valid;
  logic [3:0]  s_win_hits;

  int n_pass  = 0;
  int n_total = 0;
  bit run_cmp = 0;

  set_assoc_cache #(.ADDR_W(32), .SETS(SETS), .WAYS(WAYS), .BLOCK_BYTES(16), .CNT_W(21), .WINDOW(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .flush(flush), .hit_valid(hit_valid), .hit(hit), .hits(hits), .accesses(accesses),
    .win_valid(win_valid), .win_hits(win_hits));

  set_assoc_cache #(.ADDR_W(32), .SETS(SETS), .WAYS(WAYS), .BLOCK_BYTES(16), .CNT_W(4), .WINDOW(4)) sat_dut (
    .clk(clk), .rst_n(rst_n), .addr_in(s_addr), .addr_valid(s_valid), .addr_ready(s_ready),
    .flush(1'b0), .hit_valid(s_hit_valid), .hit(s_hit), .hits(s_hits), .accesses(s_accesses),
    .win_valid(s_win_valid), .win_hits(s_win_hits));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: per set an MRU-first list of resident tags (true LRU).
  logic [21:0] mtag [SETS][WAYS];
  int          mn   [SETS];
  int  busy = 0;
  int  exp_hits = 0, exp_acc = 0, wcnt = 0, whit = 0, exp_win_hits = 0;
  bit  exp_hv = 0, exp_hit = 0, exp_win_v = 0, exp_ready = 1;

  always @(posedge clk) begin
    int s, p, last;
    logic [21:0] t;
    bit found;
    exp_hv = 0;
    exp_win_v = 0;
    if (!rst_n) begin
      for (int k = 0; k < SETS; k++) mn[k] = 0;
      busy = 0; exp_hits = 0; exp_acc = 0; wcnt = 0; whit = 0; exp_win_hits = 0; exp_hit = 0;
    end else if (busy > 0) begin
      busy--;
    end else if (flush) begin
      busy = SETS;
      for (int k = 0; k < SETS; k++) mn[k] = 0;
    end else if (addr_valid) begin
      s = int'(addr_in[9:4]);
      t = addr_in[31:10];
      found = 0;
      p = 0;
      for (int k = 0; k < mn[s]; k++) if (!found && mtag[s][k] == t) begin found = 1; p = k; end
      if (!found) begin
        last = (mn[s] < WAYS) ? mn[s] : WAYS - 1;
        if (mn[s] < WAYS) mn[s]++;
        p = last;
      end
      for (int k = p; k > 0; k--) mtag[s][k] = mtag[s][k-1];
      mtag[s][0] = t;
      exp_hv = 1;
      exp_hit = found;
      if (exp_acc < CNT_MAX) exp_acc++;
      if (found && exp_hits < CNT_MAX) exp_hits++;
`ifdef SAC_WINDOW_STATS_EN
      wcnt++;
      whit += int'(found);
      if (wcnt == 4) begin
        exp_win_v = 1;
        exp_win_hits = whit;
        wcnt = 0;
        whit = 0;
      end
`endif
    end
    exp_ready = (busy == 0);
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("addr_ready", addr_ready, exp_ready);
      chk("hit_valid", hit_valid, exp_hv);
      if (exp_hv) chk("hit", hit, exp_hit);
      chk("hits", hits, exp_hits);
      chk("accesses", accesses, exp_acc);
      chk("win_valid", win_valid, exp_win_v);
      chk("win_hits", win_hits, exp_win_hits);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_acc(input logic [31:0] a, input logic eh, input string nm);
    addr_in = a;
    addr_valid = 1'b1;
    @(negedge clk);
    addr_valid = 1'b0;
    chk({nm, "_hv"}, hit_valid, 1);
    chk(nm, hit, eh);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; addr_valid = 1'b0; addr_in = '0; flush = 1'b0;
    s_valid = 1'b0; s_addr = 32'h40;
    @(negedge clk);
    run_cmp = 1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", addr_ready, 1);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hits", hits, 0);
    chk("rst_accesses", accesses, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_hits", win_hits, 0);

    // Cold then warm within one line
    do_acc(32'h0000_0000, 0, "cold");
    do_acc(32'h0000_000C, 1, "warm");
    chk("cw_hits", hits, 1);
    chk("cw_accesses", accesses, 2);

    // LRU eviction in set 0
    do_reset();
    do_acc(32'h000, 0, "lru_fill0");
    do_acc(32'h400, 0, "lru_fill1");
    do_acc(32'h800, 0, "lru_fill2");
    do_acc(32'hC00, 0, "lru_fill3");
    do_acc(32'h000, 1, "lru_rehit0");
    do_acc(32'h1000, 0, "lru_new");
    do_acc(32'h400, 0, "lru_evicted");
    do_acc(32'h000, 1, "lru_kept");
    chk("lru_hits", hits, 2);
    chk("lru_accesses", accesses, 8);

    // Flush with a simultaneous access request; the access waits until the walk ends
    flush = 1'b1; addr_valid = 1'b1; addr_in = 32'h000;
    @(negedge clk);
    flush = 1'b0;
    cnt = 0;
    while (addr_ready !== 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("flush_len", cnt, 64);
    chk("flush_keep_hits", hits, 2);
    chk("flush_keep_acc", accesses, 8);
    @(negedge clk);
    addr_valid = 1'b0;
    chk("post_flush_hv", hit_valid, 1);
    chk("post_flush_miss", hit, 0);
    chk("post_flush_acc", accesses, 9);

    // Reset on the 10th flush cycle
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cnt = 1;
    while (cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("midflush_busy", addr_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", addr_ready, 1);
    chk("midrst_hits", hits, 0);
    chk("midrst_acc", accesses, 0);
    do_acc(32'h000, 0, "midrst_miss");

    // Window statistics, aligned by reset; 0x10 lands in set 1
    do_reset();
    do_acc(32'h0, 0, "win_a0");
    do_acc(32'h0, 1, "win_a1");
    do_acc(32'h0, 1, "win_a2");
    do_acc(32'h10, 0, "win_a3");
`ifdef SAC_WINDOW_STATS_EN
    chk("win1_valid", win_valid, 1);
    chk("win1_hits", win_hits, 2);
`else
    chk("win_off_valid", win_valid, 0);
`endif
    do_acc(32'h0, 1, "win_b0");
`ifdef SAC_WINDOW_STATS_EN
    chk("win_hold_valid", win_valid, 0);
    chk("win_hold_hits", win_hits, 2);
`endif
    do_acc(32'h0, 1, "win_b1");
    do_acc(32'h0, 1, "win_b2");
    do_acc(32'h0, 1, "win_b3");
`ifdef SAC_WINDOW_STATS_EN
    chk("win2_valid", win_valid, 1);
    chk("win2_hits", win_hits, 4);
`else
    chk("win_off_hits", win_hits, 0);
`endif
    chk("win_seq_hits", hits, 6);

    // Counter saturation on the narrow-counter instance
    s_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("sat_mid_hits", s_hits, 4);
    chk("sat_mid_acc", s_accesses, 5);
    repeat (15) @(negedge clk);
    s_valid = 1'b0;
    chk("sat_hits", s_hits, 15);
    chk("sat_acc", s_accesses, 15);
    @(negedge clk);
    chk("sat_idle_hv", s_hit_valid, 0);

    @(negedge clk);
    run_cmp = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
